// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_if
// Description : Request/grant and result valid/ready bundle for the shared
//               logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int IDW   = $clog2(N)
);
    logic [N-1:0]       req;
    logic [2*N-1:0]     op;
    logic [WIDTH*N-1:0] a_in;
    logic [WIDTH*N-1:0] b_in;
    logic [N-1:0]       gnt;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_y;
    logic [IDW-1:0]     res_id;
    logic [15:0]        grant_count;

    modport master (
        output req, op, a_in, b_in, res_ready,
        input  gnt, res_valid, res_y, res_id, grant_count
    );

    modport slave (
        input  req, op, a_in, b_in, res_ready,
        output gnt, res_valid, res_y, res_id, grant_count
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin sharing of one registered OR/AND/XOR/NOR unit
//               among N requesters, result returned with requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int IDW   = $clog2(N)
) (
    input  wire                   clk,
    input  wire                   reset,
    logic_unit_arbiter_if.slave   bus
);
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [IDW-1:0]   r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_y;
    logic [IDW-1:0]   r_id;
    logic [15:0]      r_cnt;

    int               w_idx;
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    logic             w_free;
    logic             w_accept;
    logic [N-1:0]     w_gnt;

    assign w_free   = !r_valid || bus.res_ready;
    assign w_accept = w_found && w_free && !reset;

    // First set request at or after the pointer, wrapping modulo N.
    always_comb begin
        w_idx   = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int k = 0; k < N; k++) begin
            if (IDW'(k) == w_win) begin
                w_op = bus.op[2*k +: 2];
                w_a  = bus.a_in[WIDTH*k +: WIDTH];
                w_b  = bus.b_in[WIDTH*k +: WIDTH];
            end
        end
    end

    always_comb begin
        w_y = '0;
        case (w_op)
            2'b00:   w_y = w_a | w_b;
            2'b01:   w_y = w_a & w_b;
            2'b10:   w_y = w_a ^ w_b;
            default: w_y = ~(w_a | w_b);
        endcase
    end

    always_comb begin
        w_gnt = '0;
        if (w_accept) w_gnt[w_win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_y     <= w_y;
            r_id    <= w_win;
            r_ptr   <= (w_win == IDW'(N-1)) ? '0 : w_win + 1'b1;
            if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 16'd1;
        end else if (r_valid && bus.res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.res_valid   = r_valid;
    assign bus.res_y       = r_y;
    assign bus.res_id      = r_id;
    assign bus.grant_count = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Directed self-checking bench for logic_unit_arbiter (N=4, WIDTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errs;

    logic_unit_arbiter_if #(.N(4), .WIDTH(1)) bus ();

    logic_unit_arbiter #(.N(4), .WIDTH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_y;
        n_checks      = 0;
        n_errs        = 0;
        exp_y         = 4'b0101;   // OR, AND, XOR, NOR of a=1,b=0
        reset         = 1'b1;
        bus.req       = 4'b1111;
        bus.op        = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.res_ready = 1'b1;

        // Reset with every requester active
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        tick();
        check("rst_gnt2", 32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.res_valid), 32'h0);
        check("rst_y", 32'(bus.res_y), 32'h0);
        check("rst_id", 32'(bus.res_id), 32'h0);
        check("rst_cnt", 32'(bus.grant_count), 32'h0);
        reset = 1'b0;
        #1;
        check("first_gnt", 32'(bus.gnt), 32'h1);
        tick();
        check("first_valid", 32'(bus.res_valid), 32'h1);
        check("first_id", 32'(bus.res_id), 32'h0);
        check("second_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        tick();
        check("drain_valid", 32'(bus.res_valid), 32'h0);
        check("drain_id_hold", 32'(bus.res_id), 32'h0);
        check("cnt_1", 32'(bus.grant_count), 32'h1);

        // Requester 2 alone, each operation with a=1, b=0
        bus.a_in = 4'b0100;
        bus.b_in = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            bus.op[5:4] = 2'(o);
            bus.req     = 4'b0100;
            #1;
            check("op_gnt", 32'(bus.gnt), 32'h4);
            tick();
            bus.req = 4'b0000;
            check("op_y", 32'(bus.res_y), 32'(exp_y[o]));
            check("op_id", 32'(bus.res_id), 32'h2);
        end
        check("cnt_5", 32'(bus.grant_count), 32'h5);

        // Fresh reset, then all four requesting with ready held high
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        bus.op   = '0;
        bus.a_in = 4'b0101;
        bus.b_in = 4'b0000;
        bus.req  = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << (i % 4)));
            tick();
            check("rr_id", 32'(bus.res_id), 32'(i % 4));
        end
        check("rr_cnt", 32'(bus.grant_count), 32'h5);
        check("rr_y", 32'(bus.res_y), 32'h1);

        // Backpressure: result id 0 pending, ptr=1
        bus.res_ready = 1'b0;
        bus.req       = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_gnt", 32'(bus.gnt), 32'h0);
            tick();
            check("bp_id", 32'(bus.res_id), 32'h0);
            check("bp_y", 32'(bus.res_y), 32'h1);
            check("bp_valid", 32'(bus.res_valid), 32'h1);
        end
        bus.res_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(bus.gnt), 32'h2);
        tick();
        check("bp_release_valid", 32'(bus.res_valid), 32'h1);
        check("bp_release_id", 32'(bus.res_id), 32'h1);
        check("bp_release_y", 32'(bus.res_y), 32'h0);

        // Withdraw: requester 1 pulses while blocked; ptr stays at 2
        bus.res_ready = 1'b0;
        bus.req       = 4'b0010;
        #1;
        check("wd_gnt", 32'(bus.gnt), 32'h0);
        tick();
        bus.req = 4'b0000;
        #1;
        check("wd_gnt_idle", 32'(bus.gnt), 32'h0);
        tick();
        check("wd_id", 32'(bus.res_id), 32'h1);
        bus.req       = 4'b1011;
        bus.res_ready = 1'b1;
        #1;
        check("wd_after_gnt", 32'(bus.gnt), 32'h8);
        tick();
        check("wd_after_id", 32'(bus.res_id), 32'h3);
        check("wd_cnt", 32'(bus.grant_count), 32'h7);

        // Reset while a result is pending and requests are active
        bus.req       = 4'b1111;
        bus.res_ready = 1'b0;
        reset         = 1'b1;
        #1;
        bus.res_ready = 1'b1;
        #1;
        check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
        tick();
        check("rst_mid_valid", 32'(bus.res_valid), 32'h0);
        check("rst_mid_cnt", 32'(bus.grant_count), 32'h0);
        check("rst_mid_id", 32'(bus.res_id), 32'h0);
        reset = 1'b0;

        // Saturation of grant_count
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(bus.grant_count), 32'hFFFE);
        tick();
        check("sat_ffff", 32'(bus.grant_count), 32'hFFFF);
        repeat (3) tick();
        check("sat_hold", 32'(bus.grant_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered 2-input bitwise logic unit (OR/AND/XOR/NOR) among N requesters.
- Each requester presents an operation and two operands with a req/gnt handshake.
- The block grants one requester per cycle, computes the result into a single output register, and returns it, tagged with the requester ID, over a valid/ready interface.
- It sits between the gate-level datapath exercises and any client logic that needs shared access to the logic unit.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 1, operand/result width in bits (1..32).
- IDW, $clog2(N), width of the requester ID.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  req[i]=1: requester i has a pending operation.
- op  input  2*N  op[2i+1:2i]: operation of requester i (00 OR, 01 AND, 10 XOR, 11 NOR).
- a_in  input  WIDTH*N  operand a of requester i at bits [WIDTH*i +: WIDTH].
- b_in  input  WIDTH*N  operand b of requester i, same packing.
- gnt  output  N  one-hot acceptance pulse, combinational, for the cycle the request is accepted.
- res_valid  output  1  the result register holds an undelivered result.
- res_ready  input  1  consumer accepts the result when res_valid&res_ready.
- res_y  output  WIDTH  result value.
- res_id  output  IDW  index of the requester that produced res_y.
- grant_count  output  16  total accepted operations; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=1 at a clock edge): res_valid=0, res_y=0, res_id=0, grant_count=0, round-robin pointer ptr=0.
- gnt is forced to 0 while reset=1.
- Slot free condition: free = !res_valid | res_ready.
  - Accept only when free and |req.
  - Otherwise gnt=0 and no state changes except a drain.
- Arbitration: search req starting at index ptr, wrapping modulo N. The first set bit k wins, and gnt[k]=1 for that cycle only.
  - Exactly zero or one gnt bit is set in any cycle.
- Acceptance at edge t, in the gnt cycle:
  - res_y <= f(op[k], a_in[k], b_in[k]), computed bitwise.
  - res_id <= k.
  - res_valid <= 1.
  - ptr <= (k+1) mod N.
  - grant_count <= grant_count+1 unless it is already 16'hFFFF.
- Latency: result is visible one cycle after gnt. Maximum throughput is one op per cycle when res_ready is held at 1.
- Drain: res_valid&res_ready without a new acceptance sets res_valid <= 0. res_y and res_id hold their last values.
- Drain and accept in the same cycle: the new result replaces the old, and res_valid stays 1.
- Backpressure: res_valid=1 with res_ready=0 holds res_y, res_id and ptr stable, and gnt=0.
- Requester rules:
  - A requester keeps req, op, a_in and b_in stable until it sees gnt.
  - It may deassert req (withdraw) at any time before gnt; a withdrawn request is never granted.
  - A requester holding req=1 after gnt issues a new operation, which is arbitrated fresh.
- Fairness: with all N requesting continuously and res_ready=1, grants cycle 0,1,..,N-1,0,...
  - No requester waits more than N-1 accepted grants.
- ptr does not move when no grant occurs.
- Reset mid-operation: a pending result is discarded (res_valid=0), and no gnt is issued in the reset cycle.

Test Plan:
- Reset with all req=1 -> gnt=0 during reset.
  - First cycle after reset: gnt=4'b0001.
  - Next cycle: res_valid=1, res_id=0.
- Single requester 2: op=00, WIDTH=1, a=1, b=0 -> gnt=4'b0100, then res_y=1, res_id=2.
  - Repeat with op=01 -> res_y=0.
  - Repeat with op=10 -> res_y=1.
  - Repeat with op=11 -> res_y=0.
- All four req=1, res_ready=1 held -> gnt sequence 0001, 0010, 0100, 1000, 0001.
  - res_id follows 0,1,2,3,0 one cycle later.
  - grant_count=5 after five grants.
- Backpressure: result pending, res_ready=0 for 3 cycles with req=4'b0011 -> gnt=0, and res_y/res_id unchanged.
  - Raise res_ready -> the same-cycle grant goes to the ptr-next requester, and res_valid stays 1.
- Withdraw: req[1] pulses for one cycle while the output is blocked -> requester 1 is never granted, and ptr is unchanged.
- Assert reset while res_valid=1 and req active -> res_valid=0 and grant_count=0 next edge, and gnt=0 during reset.
- Saturation: 65536 grants -> grant_count holds at 16'hFFFF.
